// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - note frequency table, mode encoding and width helpers shared by poly_player_ctrl
package player_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_REC  = 2'd1,
      MODE_PLAY = 2'd2
   } mode_t;

   localparam int N_NOTES = 48;

   // Equal-tempered pitches in whole Hz (fraction truncated), index 0 = C3
   localparam int FREQ [N_NOTES] = '{
       130,  138,  146,  155,  164,  174,  184,  195,  207,  220,  233,  246,
       261,  277,  293,  311,  329,  349,  369,  391,  415,  440,  466,  493,
       523,  554,  587,  622,  659,  698,  739,  783,  830,  880,  932,  987,
      1046, 1108, 1174, 1244, 1318, 1396, 1479, 1567, 1661, 1760, 1864, 1975
   };

   function automatic int note_w(input int n_keys);
      return $clog2(n_keys + 1);
   endfunction

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int len_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/poly_player_ctrl_if.sv
// rtl/poly_player_ctrl_if.sv - key/control inputs and voice/status outputs of poly_player_ctrl
interface poly_player_ctrl_if
   import player_pkg::*;
#(
   parameter int N_KEYS    = 48,
   parameter int N_VOICES  = 2,
   parameter int REC_DEPTH = 512
);
   localparam int NW = note_w(N_KEYS);
   localparam int LW = len_w(REC_DEPTH);

   logic [N_KEYS-1:0]      keys;
   logic                   rec_start;
   logic                   play_start;
   logic                   stop;
   logic [N_VOICES-1:0]    tone_out;
   logic [N_VOICES*NW-1:0] note_code;
   logic [1:0]             mode;
   logic [LW-1:0]          rec_len;

   modport master (
      output keys, rec_start, play_start, stop,
      input  tone_out, note_code, mode, rec_len
   );

   modport slave (
      input  keys, rec_start, play_start, stop,
      output tone_out, note_code, mode, rec_len
   );

endinterface

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square wave for one voice; code k+1 toggles every CLK_HZ/(2*FREQ[k]) cycles, code 0 is silent
module tone_gen
   import player_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int NW     = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [NW-1:0] code,
   output logic          tone
);
   localparam int CW = $clog2(CLK_HZ / (2 * FREQ[0]) + 1);

   logic [CW-1:0] half_rom [N_NOTES];
   logic [CW-1:0] half;
   logic [CW-1:0] cnt;
   logic [NW-1:0] code_q;

   for (genvar k = 0; k < N_NOTES; k++) begin : g_rom
      assign half_rom[k] = CW'(CLK_HZ / (2 * FREQ[k]));
   end

   always_comb begin
      half = '0;
      if (code != '0)
         half = half_rom[6'(code - 1'b1)];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q <= '0;
         cnt    <= '0;
         tone   <= 1'b0;
      end else begin
         code_q <= code;
         // a new note restarts its phase low so every voice starts cleanly
         if (code != code_q || code == '0) begin
            cnt  <= '0;
            tone <= 1'b0;
         end else if (cnt == half - 1'b1) begin
            cnt  <= '0;
            tone <= ~tone;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/poly_player_ctrl.sv
// rtl/poly_player_ctrl.sv - polyphonic key player with beat-rate record/playback buffer; PLAYER_LOOP_EN makes playback repeat until stop
module poly_player_ctrl
   import player_pkg::*;
#(
   parameter int N_KEYS    = 48,
   parameter int N_VOICES  = 2,
   parameter int REC_DEPTH = 512,
   parameter int CLK_HZ    = 100_000_000,
   parameter int BEAT_HZ   = 8
) (
   input logic              clk,
   input logic              reset,
   poly_player_ctrl_if.slave bus
);
   localparam int NW       = note_w(N_KEYS);
   localparam int AW       = addr_w(REC_DEPTH);
   localparam int LW       = len_w(REC_DEPTH);
   localparam int VW       = N_VOICES * NW;
   localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;
   localparam int BW       = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

   mode_t               state;
   logic [BW-1:0]       beat_cnt;
   logic [LW-1:0]       wr_ptr, rd_ptr, rec_len;
   logic [VW-1:0]       note_code, live_code, rd_data;
   logic [VW-1:0]       mem [REC_DEPTH];
   logic                load_pending;
   logic                tick, at_end, wr_en;
   logic [AW-1:0]       rd_addr;
   logic [N_VOICES-1:0] tone;

   assign tick   = (beat_cnt == BW'(BEAT_DIV - 1));
   assign at_end = (rd_ptr == rec_len);
   assign wr_en  = (state == MODE_REC) && tick && !bus.stop;
`ifdef PLAYER_LOOP_EN
   assign rd_addr = at_end ? '0 : rd_ptr[AW-1:0];
`else
   assign rd_addr = rd_ptr[AW-1:0];
`endif

   // lowest-index pressed keys fill voices in order; surplus keys are dropped
   always_comb begin
      int n;
      live_code = '0;
      n = 0;
      for (int k = 0; k < N_KEYS; k++) begin
         if (bus.keys[k] && n < N_VOICES) begin
            live_code[n*NW +: NW] = NW'(k + 1);
            n++;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= note_code;
      rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= MODE_IDLE;
         beat_cnt     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         rec_len      <= '0;
         note_code    <= '0;
         load_pending <= 1'b0;
      end else begin
         beat_cnt     <= tick ? '0 : beat_cnt + 1'b1;
         load_pending <= 1'b0;
         case (state)
            MODE_IDLE: begin
               note_code <= live_code;
               if (!bus.stop && bus.rec_start) begin
                  state    <= MODE_REC;
                  wr_ptr   <= '0;
                  beat_cnt <= '0;
               end else if (!bus.stop && bus.play_start && rec_len != '0) begin
                  state     <= MODE_PLAY;
                  rd_ptr    <= '0;
                  beat_cnt  <= '0;
                  note_code <= '0;
               end
            end
            MODE_REC: begin
               note_code <= live_code;
               if (bus.stop) begin
                  state    <= MODE_IDLE;
                  rec_len  <= wr_ptr;
                  beat_cnt <= '0;
               end else if (tick) begin
                  if (wr_ptr == LW'(REC_DEPTH - 1)) begin
                     state   <= MODE_IDLE;
                     rec_len <= LW'(REC_DEPTH);
                  end else begin
                     wr_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
            MODE_PLAY: begin
               // rd_data holds the word addressed on the previous tick
               if (load_pending)
                  note_code <= rd_data;
               if (bus.stop) begin
                  state     <= MODE_IDLE;
                  note_code <= '0;
                  beat_cnt  <= '0;
               end else if (tick) begin
                  if (at_end) begin
`ifdef PLAYER_LOOP_EN
                     rd_ptr       <= LW'(1);
                     load_pending <= 1'b1;
`else
                     state     <= MODE_IDLE;
                     note_code <= '0;
`endif
                  end else begin
                     rd_ptr       <= rd_ptr + 1'b1;
                     load_pending <= 1'b1;
                  end
               end
            end
            default: state <= MODE_IDLE;
         endcase
      end
   end

   for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
      tone_gen #(
         .CLK_HZ (CLK_HZ),
         .NW     (NW)
      ) u_tone (
         .clk  (clk),
         .rst  (reset),
         .code (note_code[v*NW +: NW]),
         .tone (tone[v])
      );
   end

   assign bus.tone_out  = tone;
   assign bus.note_code = note_code;
   assign bus.mode      = state;
   assign bus.rec_len   = rec_len;

endmodule

// File: tb/tb_poly_player_ctrl.sv
// tb/tb_poly_player_ctrl.sv - directed self-checking bench for poly_player_ctrl at 1 MHz clock, 1 kHz beat
module tb_poly_player_ctrl;
   localparam int N_KEYS    = 48;
   localparam int N_VOICES  = 2;
   localparam int REC_DEPTH = 4;
   localparam int CLK_HZ    = 1_000_000;
   localparam int BEAT_HZ   = 1000;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   t0, t1;

   poly_player_ctrl_if #(
      .N_KEYS    (N_KEYS),
      .N_VOICES  (N_VOICES),
      .REC_DEPTH (REC_DEPTH)
   ) bus ();

   poly_player_ctrl #(
      .N_KEYS    (N_KEYS),
      .N_VOICES  (N_VOICES),
      .REC_DEPTH (REC_DEPTH),
      .CLK_HZ    (CLK_HZ),
      .BEAT_HZ   (BEAT_HZ)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic rs, input logic ps, input logic sp);
      @(posedge clk);
      #1;
      bus.rec_start  = rs;
      bus.play_start = ps;
      bus.stop       = sp;
      @(posedge clk);
      #1;
      bus.rec_start  = 1'b0;
      bus.play_start = 1'b0;
      bus.stop       = 1'b0;
   endtask

   task automatic wait_toggle(input int v, output int at);
      logic prev;
      prev = bus.tone_out[v];
      at   = -1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (bus.tone_out[v] !== prev) begin
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      bus.keys       = '0;
      bus.rec_start  = 1'b0;
      bus.play_start = 1'b0;
      bus.stop       = 1'b0;
      step(3);
      check_eq("rst_mode", bus.mode, 0);
      check_eq("rst_note", bus.note_code, 0);
      check_eq("rst_tone", bus.tone_out, 0);
      check_eq("rst_len", bus.rec_len, 0);
      reset = 1'b0;
      step(2);

      // live keys 21 (A4) and 33 (A5)
      bus.keys[21] = 1'b1;
      bus.keys[33] = 1'b1;
      check_eq("live_latency", bus.note_code, 0);
      step(1);
      check_eq("live_code", bus.note_code, {6'd34, 6'd22});
      wait_toggle(0, t0);
      wait_toggle(0, t1);
      check_eq("tone0_half", t1 - t0, 1136);
      wait_toggle(1, t0);
      wait_toggle(1, t1);
      check_eq("tone1_half", t1 - t0, 568);

      // allocation with a dropped third key
      bus.keys    = '0;
      bus.keys[2] = 1'b1;
      bus.keys[5] = 1'b1;
      bus.keys[9] = 1'b1;
      step(1);
      check_eq("alloc_code", bus.note_code, {6'd6, 6'd3});
      bus.keys = '0;
      step(2);

      // priority and empty playback
      pulse(1'b1, 1'b0, 1'b1);
      check_eq("prio_stop_rec", bus.mode, 0);
      pulse(1'b1, 1'b1, 1'b0);
      check_eq("prio_rec_play", bus.mode, 1);
      pulse(1'b0, 1'b0, 1'b1);
      check_eq("zero_rec_mode", bus.mode, 0);
      check_eq("zero_rec_len", bus.rec_len, 0);
      pulse(1'b0, 1'b1, 1'b0);
      check_eq("empty_play", bus.mode, 0);

      // record until full with key 0 held
      bus.keys[0] = 1'b1;
      step(2);
      pulse(1'b1, 1'b0, 1'b0);
      check_eq("full_enter", bus.mode, 1);
      step(3999);
      check_eq("full_pre", bus.mode, 1);
      step(1);
      check_eq("full_mode", bus.mode, 0);
      check_eq("full_len", bus.rec_len, 4);

      pulse(1'b0, 1'b1, 1'b0);
      check_eq("pf_mode", bus.mode, 2);
      check_eq("pf_silent", bus.note_code, 0);
      step(1000);
      check_eq("pf_tick1", bus.note_code, 0);
      step(1);
      check_eq("pf_load1", bus.note_code, 1);
      step(3998);
      check_eq("pf_pre_end", bus.mode, 2);
      step(1);
`ifdef PLAYER_LOOP_EN
      check_eq("pf_loop_mode", bus.mode, 2);
      step(1);
      check_eq("pf_loop_code", bus.note_code, 1);
      pulse(1'b0, 1'b0, 1'b1);
      check_eq("pf_loop_stop", bus.mode, 0);
`else
      check_eq("pf_end_mode", bus.mode, 0);
      check_eq("pf_end_note", bus.note_code, 0);
`endif
      bus.keys = '0;

      // two-beat recording with a key change between beats
      bus.keys[21] = 1'b1;
      bus.keys[33] = 1'b1;
      step(2);
      pulse(1'b1, 1'b0, 1'b0);
      step(1000);
      bus.keys     = '0;
      bus.keys[10] = 1'b1;
      step(1000);
      pulse(1'b0, 1'b0, 1'b1);
      check_eq("rp_mode", bus.mode, 0);
      check_eq("rp_len", bus.rec_len, 2);

      pulse(1'b0, 1'b1, 1'b0);
      step(1000);
      check_eq("rp_tick1", bus.note_code, 0);
      step(1);
      check_eq("rp_code1", bus.note_code, 2198);
      step(1000);
      check_eq("rp_code2", bus.note_code, 11);
      step(998);
      check_eq("rp_pre_end", bus.mode, 2);
      step(1);
`ifdef PLAYER_LOOP_EN
      check_eq("rp_loop_mode", bus.mode, 2);
      step(1);
      check_eq("rp_loop_code", bus.note_code, 2198);
      pulse(1'b0, 1'b0, 1'b1);
`else
      check_eq("rp_end_mode", bus.mode, 0);
      check_eq("rp_end_note", bus.note_code, 0);
`endif
      bus.keys = '0;
      step(2);

      // asynchronous reset in the middle of playback
      pulse(1'b0, 1'b1, 1'b0);
      t0 = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (bus.tone_out != '0) begin
            t0 = 1;
            break;
         end
      end
      check_eq("mid_play_tone", t0, 1);
      check_eq("mid_play_mode", bus.mode, 2);
      reset = 1'b1;
      #1;
      check_eq("arst_mode", bus.mode, 0);
      check_eq("arst_tone", bus.tone_out, 0);
      check_eq("arst_len", bus.rec_len, 0);
      step(2);
      reset = 1'b0;
      step(2);
      check_eq("post_rst_mode", bus.mode, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
